// File: rtl/score_display_driver.sv
// rtl/score_display_driver.sv - binary score to six active-low 7-segment digits via sequential double-dabble
// Optional high-score alternation is built when SCORE_DISPLAY_HIGH_SCORE_EN is defined.
module score_display_driver #(
    parameter int unsigned BLANK_LEADING = 1,
    parameter int unsigned BLINK_CYCLES  = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] score,
    input  logic        game_over,
    input  logic        hs_clear,
    output logic        busy,
    output logic [23:0] bcd_value,
    output logic        hs_shown,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);

    localparam logic [6:0] SEG_BLANK      = 7'h7F;
    localparam logic [6:0] SEG_ZERO       = 7'b1000000;
    localparam logic [6:0] SEG_LEAD_RESET = (BLANK_LEADING != 0) ? SEG_BLANK : SEG_ZERO;
    localparam logic [4:0] BIT_COUNT      = 5'd17;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LATCH
    } state_t;

    state_t      state;
    logic [16:0] src;
    logic [16:0] last_bin;
    logic [16:0] bin_sr;
    logic [23:0] bcd_acc;
    logic [23:0] bcd_adj;
    logic [4:0]  bitcnt;
    logic [6:0]  seg_next [6];

`ifdef SCORE_DISPLAY_HIGH_SCORE_EN
    localparam int unsigned PHASE = (BLINK_CYCLES == 0) ? 1 : BLINK_CYCLES;
    localparam int          CW    = $clog2(PHASE + 1);

    logic [16:0]   high_score;
    logic [CW-1:0] blink_cnt;

    // Deliberately outside rst so a board reset keeps the record; FPGA power-up state is 0.
    always_ff @(posedge clk) begin
        if (hs_clear) begin
            high_score <= '0;
        end else if (!game_over && (score > high_score)) begin
            high_score <= score;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt <= '0;
            hs_shown  <= 1'b0;
        end else if (!game_over) begin
            blink_cnt <= '0;
            hs_shown  <= 1'b0;
        end else if (blink_cnt == CW'(PHASE - 1)) begin
            blink_cnt <= '0;
            hs_shown  <= ~hs_shown;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign src = hs_shown ? high_score : score;
`else
    logic unused_inputs;

    assign hs_shown      = 1'b0;
    assign src           = score;
    assign unused_inputs = &{1'b0, game_over, hs_clear, BLINK_CYCLES[0]};
`endif

    function automatic logic [6:0] seg7(input logic [3:0] digit);
        case (digit)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Double-dabble correction: any nibble >= 5 would overflow past 9 on the next shift.
    always_comb begin
        bcd_adj = bcd_acc;
        for (int i = 0; i < 6; i++) begin
            if (bcd_acc[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_acc[4*i +: 4] + 4'd3;
            end
        end
    end

    // A digit is a leading zero when it and every digit above it are zero; HEX0 always stays lit.
    always_comb begin
        for (int d = 0; d < 6; d++) begin
            seg_next[d] = seg7(bcd_acc[4*d +: 4]);
            if ((BLANK_LEADING != 0) && (d != 0) && ((bcd_acc >> (4 * d)) == 24'd0)) begin
                seg_next[d] = SEG_BLANK;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_bin  <= '0;
            bin_sr    <= '0;
            bcd_acc   <= '0;
            bitcnt    <= '0;
            busy      <= 1'b0;
            bcd_value <= '0;
            hex0      <= SEG_ZERO;
            hex1      <= SEG_LEAD_RESET;
            hex2      <= SEG_LEAD_RESET;
            hex3      <= SEG_LEAD_RESET;
            hex4      <= SEG_LEAD_RESET;
            hex5      <= SEG_LEAD_RESET;
        end else begin
            case (state)
                IDLE: begin
                    if (src != last_bin) begin
                        bin_sr   <= src;
                        last_bin <= src;
                        bcd_acc  <= '0;
                        bitcnt   <= BIT_COUNT;
                        busy     <= 1'b1;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    bcd_acc <= {bcd_adj[22:0], bin_sr[16]};
                    bin_sr  <= {bin_sr[15:0], 1'b0};
                    bitcnt  <= bitcnt - 1'b1;
                    if (bitcnt == 5'd1) begin
                        state <= LATCH;
                    end
                end
                LATCH: begin
                    bcd_value <= bcd_acc;
                    busy      <= 1'b0;
                    hex0      <= seg_next[0];
                    hex1      <= seg_next[1];
                    hex2      <= seg_next[2];
                    hex3      <= seg_next[3];
                    hex4      <= seg_next[4];
                    hex5      <= seg_next[5];
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
